// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
//   Load/store unit placed after the ALU. The ALU sum is the effective
//   address. The unit performs byte, half and word loads and stores over a
//   req/gnt/rvalid data-memory port and formats load data for write-back.
//   While a transaction is outstanding it stalls the single-cycle core.
//   Misaligned accesses and illegal funct3 values are flagged and never
//   reach memory.
//
//   Optional feature: define LSU_TIMEOUT_EN to abort an access that waits
//   TIMEOUT_CYCLES cycles for gnt (in REQ) or rvalid (in WAIT).
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   lsu_req_i           memory instruction present this cycle
//   lsu_we_i            1 = store, 0 = load
//   lsu_funct3_i        size/sign encoding
//   lsu_addr_i          effective address
//   lsu_wdata_i         store data (rs2)
//   lsu_stall_o         hold PC / register file
//   lsu_done_o          one-cycle completion pulse
//   lsu_rdata_o         formatted load data (valid with lsu_done_o)
//   lsu_misalign_o      completed access was misaligned
//   lsu_err_o           illegal funct3 or timeout
//   mem_req_o/we_o      memory request / write
//   mem_addr_o          word-aligned address
//   mem_be_o            byte enables
//   mem_wdata_o         lane-replicated store data
//   mem_gnt_i           request accepted
//   mem_rvalid_i        read data valid
//   mem_rdata_i         read data word

module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        err_q, err_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Decode of the incoming request
  logic        illegal_in;
  logic        misalign_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    if (lsu_we_i) begin
      illegal_in = (lsu_funct3_i >= 3'b011);
    end else begin
      illegal_in = (lsu_funct3_i == 3'b011) || (lsu_funct3_i == 3'b110) ||
                   (lsu_funct3_i == 3'b111);
    end

    case (lsu_funct3_i[1:0])
      2'b01:   misalign_in = lsu_addr_i[0];
      2'b10:   misalign_in = (lsu_addr_i[1:0] != 2'b00);
      default: misalign_in = 1'b0;
    endcase

    // Loads drive the same size/offset enables as stores.
    case (lsu_funct3_i[1:0])
      2'b00: begin
        be_in    = 4'b0001 << lsu_addr_i[1:0];
        wdata_in = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_in = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = lsu_wdata_i;
      end
    endcase
  end

  // Lane select plus sign/zero extension of a returned word
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'd0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'd0, h};
      3'b010:  fmt_load = word;
      default: fmt_load = '0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    // Completion outputs are pulses: cleared unless set below.
    done_d      = 1'b0;
    rdata_d     = '0;
    misalign_d  = 1'b0;
    err_d       = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (lsu_req_i) begin
          funct3_d = lsu_funct3_i;
          off_d    = lsu_addr_i[1:0];
          if (illegal_in) begin
            // Illegal wins over misaligned.
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (misalign_in) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = lsu_we_i;
            mem_addr_d  = {lsu_addr_i[31:2], 2'b00};
            mem_be_d    = be_in;
            mem_wdata_d = wdata_in;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end

      S_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          if (mem_we_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          state_d     = S_DONE;
          done_d      = 1'b1;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = fmt_load(funct3_q, off_q, mem_rdata_i);
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Stall is combinational so the core freezes in the request cycle itself.
  assign lsu_stall_o    = ((state_q == S_IDLE) && lsu_req_i) ||
                          (state_q == S_REQ) || (state_q == S_WAIT);
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_err_o      = err_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_be_o       = mem_be_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule
